// File: rtl/amber_stg_ex.sv
// Amber pipeline execute stage: ALU, address generation, condition evaluation,
// branches and kernel return, with a single registered output bundle.
module amber_stg_ex #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 24,
    parameter int OPC_W  = 8,
    parameter int CC_W   = 4,
    parameter int GP_W   = 4,
    parameter int AR_W   = 2,
    parameter int SR_W   = 2
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [ADDR_W-1:0] iw_pc,
    output logic [ADDR_W-1:0] ow_pc,
    input  logic [DATA_W-1:0] iw_instr,
    output logic [DATA_W-1:0] ow_instr,
    input  logic [OPC_W-1:0]  iw_opc,
    output logic [OPC_W-1:0]  ow_opc,
    input  logic              iw_sgn_en,
    input  logic              iw_imm_en,
    input  logic [15:0]       iw_imm16_val,
    input  logic [13:0]       iw_imm14_val,
    input  logic [11:0]       iw_imm12_val,
    input  logic [9:0]        iw_imm10_val,
    input  logic [CC_W-1:0]   iw_cc,
    input  logic [GP_W-1:0]   iw_tgt_gp,
    input  logic              iw_tgt_gp_we,
    output logic [GP_W-1:0]   ow_tgt_gp,
    output logic              ow_tgt_gp_we,
    input  logic [SR_W-1:0]   iw_tgt_sr,
    input  logic              iw_tgt_sr_we,
    output logic [SR_W-1:0]   ow_tgt_sr,
    output logic              ow_tgt_sr_we,
    input  logic [AR_W-1:0]   iw_tgt_ar,
    output logic [AR_W-1:0]   ow_tgt_ar,
    output logic              ow_tgt_ar_we,
    input  logic [GP_W-1:0]   iw_src_gp,
    input  logic [AR_W-1:0]   iw_src_ar,
    input  logic [SR_W-1:0]   iw_src_sr,
    input  logic [DATA_W-1:0] iw_src_gp_val,
    input  logic [DATA_W-1:0] iw_tgt_gp_val,
    input  logic [ADDR_W-1:0] iw_src_ar_val,
    input  logic [ADDR_W-1:0] iw_tgt_ar_val,
    input  logic [ADDR_W-1:0] iw_src_sr_val,
    input  logic [ADDR_W-1:0] iw_tgt_sr_val,
    output logic [ADDR_W-1:0] ow_addr,
    output logic [DATA_W-1:0] ow_result,
    output logic [ADDR_W-1:0] ow_ar_result,
    output logic [ADDR_W-1:0] ow_sr_result,
    output logic              ow_branch_taken,
    output logic [ADDR_W-1:0] ow_branch_pc,
    input  logic              iw_flush,
    input  logic              iw_stall
);

    localparam logic [OPC_W-1:0] OPC_NOP  = 8'd0;
    localparam logic [OPC_W-1:0] OPC_MOV  = 8'd1;
    localparam logic [OPC_W-1:0] OPC_ADD  = 8'd2;
    localparam logic [OPC_W-1:0] OPC_SUB  = 8'd3;
    localparam logic [OPC_W-1:0] OPC_AND  = 8'd4;
    localparam logic [OPC_W-1:0] OPC_OR   = 8'd5;
    localparam logic [OPC_W-1:0] OPC_XOR  = 8'd6;
    localparam logic [OPC_W-1:0] OPC_SHL  = 8'd7;
    localparam logic [OPC_W-1:0] OPC_SHR  = 8'd8;
    localparam logic [OPC_W-1:0] OPC_CMP  = 8'd9;
    localparam logic [OPC_W-1:0] OPC_LD   = 8'd10;
    localparam logic [OPC_W-1:0] OPC_ST   = 8'd11;
    localparam logic [OPC_W-1:0] OPC_ADDA = 8'd12;
    localparam logic [OPC_W-1:0] OPC_BCC  = 8'd13;
    localparam logic [OPC_W-1:0] OPC_JCC  = 8'd14;
    localparam logic [OPC_W-1:0] OPC_JSR  = 8'd15;
    localparam logic [OPC_W-1:0] OPC_KRET = 8'd16;

    localparam logic [CC_W-1:0] CC_AL  = 4'd0;
    localparam logic [CC_W-1:0] CC_EQ  = 4'd1;
    localparam logic [CC_W-1:0] CC_NE  = 4'd2;
    localparam logic [CC_W-1:0] CC_LT  = 4'd3;
    localparam logic [CC_W-1:0] CC_GE  = 4'd4;
    localparam logic [CC_W-1:0] CC_LTU = 4'd5;
    localparam logic [CC_W-1:0] CC_GEU = 4'd6;
    localparam logic [CC_W-1:0] CC_MI  = 4'd7;
    localparam logic [CC_W-1:0] CC_PL  = 4'd8;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // C carries the carry-out for ADD and the borrow for SUB/CMP, so LTU == C.
    function automatic logic f_cond_true(input logic [CC_W-1:0] cc,
                                         input logic z, input logic n,
                                         input logic c, input logic v);
        logic t;
        case (cc)
            CC_AL:   t = 1'b1;
            CC_EQ:   t = z;
            CC_NE:   t = ~z;
            CC_LT:   t = n ^ v;
            CC_GE:   t = ~(n ^ v);
            CC_LTU:  t = c;
            CC_GEU:  t = ~c;
            CC_MI:   t = n;
            CC_PL:   t = ~n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [ADDR_W-1:0] r_pc, r_addr, r_ar_result, r_sr_result, r_branch_pc;
    logic [DATA_W-1:0] r_instr, r_result;
    logic [OPC_W-1:0]  r_opc;
    logic [GP_W-1:0]   r_tgt_gp;
    logic [SR_W-1:0]   r_tgt_sr;
    logic [AR_W-1:0]   r_tgt_ar;
    logic              r_tgt_gp_we, r_tgt_sr_we, r_tgt_ar_we, r_branch_taken;
    logic              r_flag_z, r_flag_n, r_flag_c, r_flag_v;

    logic [DATA_W-1:0] w_imm12_ext, w_op_a, w_op_b, w_alu_res;
    logic [DATA_W:0]   w_sum, w_diff;
    logic [ADDR_W-1:0] w_imm16_sext, w_imm14_sext, w_imm10_sext;
    logic              w_is_alu, w_is_arith, w_cond;
    logic              w_carry, w_ovf;
    logic              w_nxt_z, w_nxt_n, w_nxt_c, w_nxt_v;
    logic [ADDR_W-1:0] w_nxt_addr, w_nxt_ar_result, w_nxt_sr_result, w_nxt_branch_pc;
    logic [DATA_W-1:0] w_nxt_result;
    logic              w_nxt_gp_we, w_nxt_sr_we, w_nxt_ar_we, w_nxt_taken;
    logic              w_unused;

    assign w_unused = ^{iw_src_gp, iw_src_ar, iw_src_sr, iw_tgt_ar_val, iw_src_sr_val};

    assign w_imm12_ext  = iw_sgn_en ? {{(DATA_W-12){iw_imm12_val[11]}}, iw_imm12_val}
                                    : {{(DATA_W-12){1'b0}}, iw_imm12_val};
    assign w_imm16_sext = {{(ADDR_W-16){iw_imm16_val[15]}}, iw_imm16_val};
    assign w_imm14_sext = {{(ADDR_W-14){iw_imm14_val[13]}}, iw_imm14_val};
    assign w_imm10_sext = {{(ADDR_W-10){iw_imm10_val[9]}}, iw_imm10_val};
    assign w_op_a       = iw_tgt_gp_val;
    assign w_op_b       = iw_imm_en ? w_imm12_ext : iw_src_gp_val;
    assign w_sum        = {1'b0, w_op_a} + {1'b0, w_op_b};
    assign w_diff       = {1'b0, w_op_a} - {1'b0, w_op_b};
    assign w_cond       = f_cond_true(iw_cc, r_flag_z, r_flag_n, r_flag_c, r_flag_v);

    // ALU result and the carry/overflow it would produce
    always_comb begin
        w_alu_res  = DATA_ZERO;
        w_is_alu   = 1'b1;
        w_is_arith = 1'b0;
        w_carry    = 1'b0;
        w_ovf      = 1'b0;
        case (iw_opc)
            OPC_MOV: w_alu_res = w_op_b;
            OPC_ADD: begin
                w_alu_res  = w_sum[DATA_W-1:0];
                w_is_arith = 1'b1;
                w_carry    = w_sum[DATA_W];
                w_ovf      = (w_op_a[DATA_W-1] == w_op_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            OPC_SUB, OPC_CMP: begin
                w_alu_res  = w_diff[DATA_W-1:0];
                w_is_arith = 1'b1;
                w_carry    = w_diff[DATA_W];
                w_ovf      = (w_op_a[DATA_W-1] != w_op_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            OPC_AND: w_alu_res = w_op_a & w_op_b;
            OPC_OR:  w_alu_res = w_op_a | w_op_b;
            OPC_XOR: w_alu_res = w_op_a ^ w_op_b;
            OPC_SHL: w_alu_res = w_op_a << w_op_b;
            OPC_SHR: w_alu_res = w_op_a >> w_op_b;
            default: w_is_alu  = 1'b0;
        endcase
    end

    // Next flag values; non-ALU ops leave the flags untouched
    always_comb begin
        w_nxt_z = r_flag_z;
        w_nxt_n = r_flag_n;
        w_nxt_c = r_flag_c;
        w_nxt_v = r_flag_v;
        if (w_is_alu) begin
            w_nxt_z = (w_alu_res == DATA_ZERO);
            w_nxt_n = w_alu_res[DATA_W-1];
            if (w_is_arith) begin
                w_nxt_c = w_carry;
                w_nxt_v = w_ovf;
            end else begin
                w_nxt_c = r_flag_c;
                w_nxt_v = r_flag_v;
            end
        end else begin
            w_nxt_z = r_flag_z;
            w_nxt_n = r_flag_n;
        end
    end

    // Per-opcode results, write enables and redirect decision
    always_comb begin
        w_nxt_result    = DATA_ZERO;
        w_nxt_addr      = ADDR_ZERO;
        w_nxt_ar_result = ADDR_ZERO;
        w_nxt_sr_result = ADDR_ZERO;
        w_nxt_taken     = 1'b0;
        w_nxt_branch_pc = ADDR_ZERO;
        w_nxt_gp_we     = iw_tgt_gp_we;
        w_nxt_sr_we     = iw_tgt_sr_we;
        w_nxt_ar_we     = 1'b0;
        case (iw_opc)
            OPC_LD: w_nxt_addr = iw_src_ar_val + w_imm10_sext;
            OPC_ST: begin
                w_nxt_addr   = iw_src_ar_val + w_imm10_sext;
                w_nxt_result = iw_tgt_gp_val;
            end
            OPC_ADDA: begin
                w_nxt_ar_result = iw_src_ar_val + w_imm14_sext;
                w_nxt_ar_we     = 1'b1;
            end
            OPC_BCC: begin
                w_nxt_taken     = w_cond;
                w_nxt_branch_pc = w_cond ? (iw_pc + w_imm16_sext) : ADDR_ZERO;
            end
            OPC_JCC: begin
                w_nxt_taken     = w_cond;
                w_nxt_branch_pc = w_cond ? iw_src_ar_val : ADDR_ZERO;
            end
            OPC_JSR: begin
                w_nxt_taken     = 1'b1;
                w_nxt_branch_pc = iw_src_ar_val;
                w_nxt_sr_result = iw_pc + ADDR_ONE;
                w_nxt_sr_we     = 1'b1;
            end
            OPC_KRET: begin
                w_nxt_taken     = 1'b1;
                w_nxt_branch_pc = iw_tgt_sr_val;
                w_nxt_gp_we     = 1'b0;
            end
            OPC_CMP: begin
                w_nxt_result = w_alu_res;
                w_nxt_gp_we  = 1'b0;
            end
            OPC_NOP: w_nxt_result = DATA_ZERO;
            default: w_nxt_result = w_is_alu ? w_alu_res : DATA_ZERO;
        endcase
    end

    // Output register bank and flags: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge iw_clk) begin
        if (iw_rst || iw_flush) begin
            r_pc           <= ADDR_ZERO;
            r_instr        <= DATA_ZERO;
            r_opc          <= OPC_NOP;
            r_tgt_gp       <= {GP_W{1'b0}};
            r_tgt_sr       <= {SR_W{1'b0}};
            r_tgt_ar       <= {AR_W{1'b0}};
            r_tgt_gp_we    <= 1'b0;
            r_tgt_sr_we    <= 1'b0;
            r_tgt_ar_we    <= 1'b0;
            r_addr         <= ADDR_ZERO;
            r_result       <= DATA_ZERO;
            r_ar_result    <= ADDR_ZERO;
            r_sr_result    <= ADDR_ZERO;
            r_branch_taken <= 1'b0;
            r_branch_pc    <= ADDR_ZERO;
            if (iw_rst) begin
                r_flag_z <= 1'b0;
                r_flag_n <= 1'b0;
                r_flag_c <= 1'b0;
                r_flag_v <= 1'b0;
            end
        end else if (!iw_stall) begin
            r_pc           <= iw_pc;
            r_instr        <= iw_instr;
            r_opc          <= iw_opc;
            r_tgt_gp       <= iw_tgt_gp;
            r_tgt_sr       <= iw_tgt_sr;
            r_tgt_ar       <= iw_tgt_ar;
            r_tgt_gp_we    <= w_nxt_gp_we;
            r_tgt_sr_we    <= w_nxt_sr_we;
            r_tgt_ar_we    <= w_nxt_ar_we;
            r_addr         <= w_nxt_addr;
            r_result       <= w_nxt_result;
            r_ar_result    <= w_nxt_ar_result;
            r_sr_result    <= w_nxt_sr_result;
            r_branch_taken <= w_nxt_taken;
            r_branch_pc    <= w_nxt_branch_pc;
            r_flag_z       <= w_nxt_z;
            r_flag_n       <= w_nxt_n;
            r_flag_c       <= w_nxt_c;
            r_flag_v       <= w_nxt_v;
        end
    end

    assign ow_pc           = r_pc;
    assign ow_instr        = r_instr;
    assign ow_opc          = r_opc;
    assign ow_tgt_gp       = r_tgt_gp;
    assign ow_tgt_gp_we    = r_tgt_gp_we;
    assign ow_tgt_sr       = r_tgt_sr;
    assign ow_tgt_sr_we    = r_tgt_sr_we;
    assign ow_tgt_ar       = r_tgt_ar;
    assign ow_tgt_ar_we    = r_tgt_ar_we;
    assign ow_addr         = r_addr;
    assign ow_result       = r_result;
    assign ow_ar_result    = r_ar_result;
    assign ow_sr_result    = r_sr_result;
    assign ow_branch_taken = r_branch_taken;
    assign ow_branch_pc    = r_branch_pc;

endmodule

// File: tb/tb_amber_stg_ex.sv
// Self-checking bench for amber_stg_ex: directed scenarios plus a random ALU sweep,
// expected outputs queued when an op is driven and popped one cycle later.
module tb_amber_stg_ex;

    localparam logic [7:0] OPC_NOP = 8'd0,  OPC_MOV = 8'd1,  OPC_ADD = 8'd2,  OPC_SUB = 8'd3;
    localparam logic [7:0] OPC_AND = 8'd4,  OPC_OR  = 8'd5,  OPC_XOR = 8'd6,  OPC_SHL = 8'd7;
    localparam logic [7:0] OPC_SHR = 8'd8,  OPC_CMP = 8'd9,  OPC_LD  = 8'd10, OPC_ST  = 8'd11;
    localparam logic [7:0] OPC_ADDA = 8'd12, OPC_BCC = 8'd13, OPC_JCC = 8'd14, OPC_JSR = 8'd15;
    localparam logic [7:0] OPC_KRET = 8'd16;
    localparam logic [3:0] CC_AL = 4'd0, CC_EQ = 4'd1, CC_NE = 4'd2, CC_LT = 4'd3, CC_GE = 4'd4;
    localparam logic [3:0] CC_LTU = 4'd5, CC_GEU = 4'd6, CC_MI = 4'd7, CC_PL = 4'd8;

    logic        iw_clk = 1'b0, iw_rst;
    logic [47:0] iw_pc, ow_pc;
    logic [23:0] iw_instr, ow_instr;
    logic [7:0]  iw_opc, ow_opc;
    logic        iw_sgn_en, iw_imm_en;
    logic [15:0] iw_imm16_val;
    logic [13:0] iw_imm14_val;
    logic [11:0] iw_imm12_val;
    logic [9:0]  iw_imm10_val;
    logic [3:0]  iw_cc, iw_tgt_gp, ow_tgt_gp, iw_src_gp;
    logic        iw_tgt_gp_we, ow_tgt_gp_we, iw_tgt_sr_we, ow_tgt_sr_we, ow_tgt_ar_we;
    logic [1:0]  iw_tgt_sr, ow_tgt_sr, iw_tgt_ar, ow_tgt_ar, iw_src_ar, iw_src_sr;
    logic [23:0] iw_src_gp_val, iw_tgt_gp_val, ow_result;
    logic [47:0] iw_src_ar_val, iw_tgt_ar_val, iw_src_sr_val, iw_tgt_sr_val;
    logic [47:0] ow_addr, ow_ar_result, ow_sr_result, ow_branch_pc;
    logic        ow_branch_taken, iw_flush, iw_stall;

    typedef struct {
        logic        taken;
        logic [47:0] bpc;
        logic [23:0] res;
        logic [47:0] addr;
        logic [47:0] ar_res;
        logic [47:0] sr_res;
        logic        gp_we;
        logic        sr_we;
        logic        ar_we;
        logic [7:0]  opc;
        logic [47:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;

    amber_stg_ex dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .ow_pc(ow_pc),
        .iw_instr(iw_instr), .ow_instr(ow_instr), .iw_opc(iw_opc), .ow_opc(ow_opc),
        .iw_sgn_en(iw_sgn_en), .iw_imm_en(iw_imm_en), .iw_imm16_val(iw_imm16_val),
        .iw_imm14_val(iw_imm14_val), .iw_imm12_val(iw_imm12_val), .iw_imm10_val(iw_imm10_val),
        .iw_cc(iw_cc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we), .ow_tgt_gp(ow_tgt_gp),
        .ow_tgt_gp_we(ow_tgt_gp_we), .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
        .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we), .iw_tgt_ar(iw_tgt_ar),
        .ow_tgt_ar(ow_tgt_ar), .ow_tgt_ar_we(ow_tgt_ar_we), .iw_src_gp(iw_src_gp),
        .iw_src_ar(iw_src_ar), .iw_src_sr(iw_src_sr), .iw_src_gp_val(iw_src_gp_val),
        .iw_tgt_gp_val(iw_tgt_gp_val), .iw_src_ar_val(iw_src_ar_val),
        .iw_tgt_ar_val(iw_tgt_ar_val), .iw_src_sr_val(iw_src_sr_val),
        .iw_tgt_sr_val(iw_tgt_sr_val), .ow_addr(ow_addr), .ow_result(ow_result),
        .ow_ar_result(ow_ar_result), .ow_sr_result(ow_sr_result),
        .ow_branch_taken(ow_branch_taken), .ow_branch_pc(ow_branch_pc),
        .iw_flush(iw_flush), .iw_stall(iw_stall)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic clr_inputs();
        iw_pc = 48'h0; iw_instr = 24'h0; iw_opc = OPC_NOP; iw_sgn_en = 1'b0; iw_imm_en = 1'b0;
        iw_imm16_val = 16'h0; iw_imm14_val = 14'h0; iw_imm12_val = 12'h0; iw_imm10_val = 10'h0;
        iw_cc = 4'h0; iw_tgt_gp = 4'h0; iw_tgt_gp_we = 1'b0; iw_tgt_sr = 2'h0; iw_tgt_sr_we = 1'b0;
        iw_tgt_ar = 2'h0; iw_src_gp = 4'h0; iw_src_ar = 2'h0; iw_src_sr = 2'h0;
        iw_src_gp_val = 24'h0; iw_tgt_gp_val = 24'h0; iw_src_ar_val = 48'h0;
        iw_tgt_ar_val = 48'h0; iw_src_sr_val = 48'h0; iw_tgt_sr_val = 48'h0;
        iw_flush = 1'b0; iw_stall = 1'b0;
    endtask

    task automatic step();
        @(posedge iw_clk);
        #1;
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z = '{taken: 1'b0, bpc: 48'h0, res: 24'h0, addr: 48'h0, ar_res: 48'h0, sr_res: 48'h0,
              gp_we: 1'b0, sr_we: 1'b0, ar_we: 1'b0, opc: 8'h0, pc: 48'h0};
        return z;
    endfunction

    task automatic test_reset();
        iw_rst = 1'b1;
        clr_inputs();
        step();
        n_cmp++; if (ow_branch_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken got=%0h exp=0", ow_branch_taken); end
        n_cmp++; if (ow_result !== 24'h0) begin n_fail++; $display("FAIL rst_result got=%0h exp=0", ow_result); end
        n_cmp++; if (ow_pc !== 48'h0 || ow_addr !== 48'h0 || ow_branch_pc !== 48'h0) begin
            n_fail++; $display("FAIL rst_addr pc=%0h addr=%0h bpc=%0h exp=0", ow_pc, ow_addr, ow_branch_pc); end
        #6 iw_rst = 1'b0;
        step();
        n_cmp++; if ({ow_branch_taken, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_opc} !== 12'h0) begin
            n_fail++; $display("FAIL idle_ctrl got=%0h exp=0", {ow_branch_taken, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_opc}); end
        n_cmp++; if (ow_ar_result !== 48'h0 || ow_sr_result !== 48'h0) begin
            n_fail++; $display("FAIL idle_res ar=%0h sr=%0h exp=0", ow_ar_result, ow_sr_result); end
    endtask

    task automatic test_kret();
        clr_inputs();
        iw_opc = OPC_KRET; iw_pc = 48'h200; iw_tgt_sr_val = 48'h0000_0ABC_DEF0; iw_tgt_gp_we = 1'b1;
        e = zero_exp(); e.taken = 1'b1; e.bpc = 48'h0000_0ABC_DEF0; e.opc = OPC_KRET; e.pc = 48'h200;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_branch_taken !== e.taken) begin n_fail++; $display("FAIL kret_taken got=%0h exp=%0h", ow_branch_taken, e.taken); end
        n_cmp++; if (ow_branch_pc !== e.bpc) begin n_fail++; $display("FAIL kret_bpc got=%0h exp=%0h", ow_branch_pc, e.bpc); end
        n_cmp++; if (ow_tgt_gp_we !== 1'b0 || ow_tgt_ar_we !== 1'b0) begin
            n_fail++; $display("FAIL kret_we gp=%0h ar=%0h exp=0", ow_tgt_gp_we, ow_tgt_ar_we); end
        n_cmp++; if (ow_pc !== e.pc || ow_opc !== e.opc) begin
            n_fail++; $display("FAIL kret_pass pc=%0h opc=%0h exp pc=%0h opc=%0h", ow_pc, ow_opc, e.pc, e.opc); end
    endtask

    task automatic test_add_imm();
        logic [3:0] ccs [4];
        logic       tk  [4];
        clr_inputs();
        iw_opc = OPC_ADD; iw_imm_en = 1'b1; iw_sgn_en = 1'b1; iw_imm12_val = 12'hFFF;
        iw_tgt_gp_val = 24'd5; iw_tgt_gp_we = 1'b1; iw_tgt_gp = 4'd7;
        e = zero_exp(); e.res = 24'd4; e.gp_we = 1'b1; e.opc = OPC_ADD;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_result !== e.res) begin n_fail++; $display("FAIL add_result got=%0h exp=%0h", ow_result, e.res); end
        n_cmp++; if (ow_tgt_gp_we !== e.gp_we || ow_tgt_gp !== 4'd7) begin
            n_fail++; $display("FAIL add_we got=%0h/%0h exp=1/7", ow_tgt_gp_we, ow_tgt_gp); end
        // flags after ADD: Z=0 N=0 C=1 V=0
        ccs = '{CC_LTU, CC_GEU, CC_EQ, CC_PL};
        tk  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            clr_inputs();
            iw_opc = OPC_BCC; iw_pc = 48'h300; iw_imm16_val = 16'h0010; iw_cc = ccs[i];
            e = zero_exp(); e.taken = tk[i]; e.bpc = tk[i] ? 48'h310 : 48'h0;
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
                n_fail++; $display("FAIL add_flag_cc%0d got=%0h/%0h exp=%0h/%0h", ccs[i], ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
        end
    endtask

    task automatic test_cmp_bcc();
        logic [3:0] ccs [4];
        logic       tk  [4];
        clr_inputs();
        iw_opc = OPC_CMP; iw_tgt_gp_val = 24'd3; iw_src_gp_val = 24'd3; iw_tgt_gp_we = 1'b1;
        e = zero_exp(); e.opc = OPC_CMP;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_tgt_gp_we !== e.gp_we) begin n_fail++; $display("FAIL cmp_we got=%0h exp=%0h", ow_tgt_gp_we, e.gp_we); end
        ccs = '{CC_EQ, CC_NE, CC_AL, 4'hF};
        tk  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            clr_inputs();
            iw_opc = OPC_BCC; iw_pc = 48'h100; iw_imm16_val = 16'hFFFE; iw_cc = ccs[i];
            e = zero_exp(); e.taken = tk[i]; e.bpc = tk[i] ? 48'hFE : 48'h0; e.pc = 48'h100;
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
                n_fail++; $display("FAIL bcc_cc%0d got=%0h/%0h exp=%0h/%0h", ccs[i], ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
        end
    endtask

    task automatic test_signed_flags();
        logic [23:0] av [2];
        logic [23:0] bv [2];
        logic [3:0]  ccs [6];
        logic        tk  [2][6];
        // 2-3: N=1 V=0 C=1;  800000-1: N=0 V=1 C=0
        av = '{24'd2, 24'h800000};
        bv = '{24'd3, 24'd1};
        ccs = '{CC_LT, CC_GE, CC_LTU, CC_GEU, CC_MI, CC_PL};
        tk[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tk[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 2; s++) begin
            clr_inputs();
            iw_opc = OPC_SUB; iw_tgt_gp_val = av[s]; iw_src_gp_val = bv[s];
            step();
            for (int i = 0; i < 6; i++) begin
                clr_inputs();
                iw_opc = OPC_JCC; iw_src_ar_val = 48'hABC; iw_cc = ccs[i];
                e = zero_exp(); e.taken = tk[s][i]; e.bpc = tk[s][i] ? 48'hABC : 48'h0;
                sb_q.push_back(e);
                step();
                e = sb_q.pop_front();
                n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
                    n_fail++; $display("FAIL sub%0d_cc%0d got=%0h/%0h exp=%0h/%0h", s, ccs[i], ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
            end
        end
    endtask

    task automatic test_jsr();
        clr_inputs();
        iw_opc = OPC_JSR; iw_src_ar_val = 48'h1234; iw_pc = 48'h50;
        e = zero_exp(); e.taken = 1'b1; e.bpc = 48'h1234; e.sr_res = 48'h51; e.sr_we = 1'b1;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
            n_fail++; $display("FAIL jsr_branch got=%0h/%0h exp=%0h/%0h", ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
        n_cmp++; if (ow_sr_result !== e.sr_res || ow_tgt_sr_we !== e.sr_we) begin
            n_fail++; $display("FAIL jsr_sr got=%0h/%0h exp=%0h/%0h", ow_sr_result, ow_tgt_sr_we, e.sr_res, e.sr_we); end
    endtask

    task automatic test_mem_addr();
        clr_inputs();
        iw_opc = OPC_LD; iw_src_ar_val = 48'h1000; iw_imm10_val = 10'h3FF;
        e = zero_exp(); e.addr = 48'hFFF;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_addr !== e.addr) begin n_fail++; $display("FAIL ld_addr got=%0h exp=%0h", ow_addr, e.addr); end
        clr_inputs();
        iw_opc = OPC_ST; iw_src_ar_val = 48'hFFFF_FFFF_FFFF; iw_imm10_val = 10'h001; iw_tgt_gp_val = 24'hA5A5A5;
        e = zero_exp(); e.addr = 48'h0; e.res = 24'hA5A5A5;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_addr !== e.addr || ow_result !== e.res) begin
            n_fail++; $display("FAIL st_wrap got=%0h/%0h exp=%0h/%0h", ow_addr, ow_result, e.addr, e.res); end
        clr_inputs();
        iw_opc = OPC_ADDA; iw_src_ar_val = 48'h10; iw_imm14_val = 14'h2000;
        e = zero_exp(); e.ar_res = 48'hFFFF_FFFF_E010; e.ar_we = 1'b1;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_ar_result !== e.ar_res || ow_tgt_ar_we !== e.ar_we) begin
            n_fail++; $display("FAIL adda got=%0h/%0h exp=%0h/%0h", ow_ar_result, ow_tgt_ar_we, e.ar_res, e.ar_we); end
    endtask

    task automatic test_alu_random();
        logic [7:0]  ops [8];
        logic [23:0] a, b;
        ops = '{OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR};
        for (int i = 0; i < 32; i++) begin
            clr_inputs();
            iw_opc = ops[i % 8];
            a = 24'($urandom);
            iw_tgt_gp_val = a;
            iw_tgt_gp_we = 1'($urandom);
            iw_imm_en = 1'($urandom);
            iw_sgn_en = 1'($urandom);
            iw_imm12_val = 12'($urandom);
            iw_src_gp_val = (iw_opc == OPC_SHL || iw_opc == OPC_SHR) ? 24'($urandom_range(0, 30)) : 24'($urandom);
            if (iw_opc == OPC_SHL || iw_opc == OPC_SHR) iw_imm_en = 1'b0;
            if (iw_imm_en) b = iw_sgn_en ? {{12{iw_imm12_val[11]}}, iw_imm12_val} : {12'h0, iw_imm12_val};
            else b = iw_src_gp_val;
            e = zero_exp(); e.gp_we = iw_tgt_gp_we; e.opc = iw_opc;
            case (iw_opc)
                OPC_MOV: e.res = b;
                OPC_ADD: e.res = a + b;
                OPC_SUB: e.res = a - b;
                OPC_AND: e.res = a & b;
                OPC_OR:  e.res = a | b;
                OPC_XOR: e.res = a ^ b;
                OPC_SHL: e.res = (b > 24'd23) ? 24'h0 : (a << b[4:0]);
                default: e.res = (b > 24'd23) ? 24'h0 : (a >> b[4:0]);
            endcase
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            n_cmp++; if (ow_result !== e.res || ow_tgt_gp_we !== e.gp_we || ow_opc !== e.opc) begin
                n_fail++; $display("FAIL alu_rand%0d opc=%0d got=%0h/%0h exp=%0h/%0h", i, e.opc, ow_result, ow_tgt_gp_we, e.res, e.gp_we); end
        end
    endtask

    task automatic test_stall_flush();
        clr_inputs();
        iw_opc = OPC_ADD; iw_tgt_gp_val = 24'd10; iw_src_gp_val = 24'd20; iw_tgt_gp_we = 1'b1;
        step();
        n_cmp++; if (ow_result !== 24'h1E) begin n_fail++; $display("FAIL pre_stall got=%0h exp=1e", ow_result); end
        clr_inputs();
        iw_stall = 1'b1; iw_opc = OPC_KRET; iw_tgt_sr_val = 48'h777; iw_pc = 48'h999;
        e = zero_exp(); e.res = 24'h1E; e.gp_we = 1'b1; e.opc = OPC_ADD;
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
            n_fail++; $display("FAIL stall_branch got=%0h/%0h exp=%0h/%0h", ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
        n_cmp++; if (ow_result !== e.res || ow_opc !== e.opc || ow_tgt_gp_we !== e.gp_we || ow_pc !== 48'h0) begin
            n_fail++; $display("FAIL stall_hold got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/0", ow_result, ow_opc, ow_tgt_gp_we, ow_pc, e.res, e.opc, e.gp_we); end
        // set Z, then a stalled and a flushed non-equal SUB must both leave it set
        clr_inputs();
        iw_opc = OPC_CMP; iw_tgt_gp_val = 24'd7; iw_src_gp_val = 24'd7;
        step();
        for (int k = 0; k < 2; k++) begin
            clr_inputs();
            iw_opc = OPC_SUB; iw_tgt_gp_val = 24'd1; iw_src_gp_val = 24'd2;
            iw_tgt_gp_we = 1'b1; iw_tgt_sr_we = 1'b1; iw_pc = 48'h888;
            iw_stall = 1'b1; iw_flush = (k == 1);
            step();
            if (k == 1) begin
                n_cmp++; if ({ow_branch_taken, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_opc} !== 12'h0 || ow_pc !== 48'h0) begin
                    n_fail++; $display("FAIL flush_bubble got=%0h pc=%0h exp=0", {ow_branch_taken, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we, ow_opc}, ow_pc); end
            end
            clr_inputs();
            iw_opc = OPC_BCC; iw_pc = 48'h400; iw_imm16_val = 16'h0004; iw_cc = CC_EQ;
            e = zero_exp(); e.taken = 1'b1; e.bpc = 48'h404;
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            n_cmp++; if (ow_branch_taken !== e.taken || ow_branch_pc !== e.bpc) begin
                n_fail++; $display("FAIL flags_hold%0d got=%0h/%0h exp=%0h/%0h", k, ow_branch_taken, ow_branch_pc, e.taken, e.bpc); end
        end
        clr_inputs();
        iw_opc = OPC_KRET; iw_tgt_sr_val = 48'h555; iw_flush = 1'b1;
        step();
        n_cmp++; if (ow_branch_taken !== 1'b0 || ow_branch_pc !== 48'h0) begin
            n_fail++; $display("FAIL flush_kret got=%0h/%0h exp=0/0", ow_branch_taken, ow_branch_pc); end
    endtask

    initial begin
        test_reset();
        test_kret();
        test_add_imm();
        test_cmp_bcc();
        test_signed_flags();
        test_jsr();
        test_mem_addr();
        test_alu_random();
        test_stall_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
